// File: rtl/btn_event_arbiter.sv
// rtl/btn_event_arbiter.sv - push-button synchroniser, stability filter and round-robin event channel
//
// Purpose: turns N raw, bouncing, asynchronous button levels into exactly one
// tagged event per physical press, served round-robin over a valid/ready channel.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset (release re-timed internally)
//   btn_raw    raw button levels, active-high
//   btn_level  filtered button levels
//   evt_valid  event offered on evt_id
//   evt_id     index of the button whose press is offered
//   evt_ready  consumer accepts the offered event this cycle
//   overrun    sticky per-button flag: a press was lost while one was pending
//   ovr_clr    single-cycle pulse clearing all overrun bits
module btn_event_arbiter #(
  parameter int N_BTN         = 4,
  parameter int STABLE_CYCLES = 16,
  parameter int ID_W          = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic             evt_valid,
  output logic [ID_W-1:0]  evt_id,
  input  logic             evt_ready,
  output logic [N_BTN-1:0] overrun,
  input  logic             ovr_clr
);

  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  typedef enum logic {
    S_IDLE,
    S_OFFER
  } state_t;

  // Reset asserts asynchronously but releases on a clock edge, so no flop
  // sees a reset removal near its active edge.
  logic [1:0]       r_rst_sync;
  logic             w_rst_n;

  logic [N_BTN-1:0] r_sync1;
  logic [N_BTN-1:0] r_sync2;
  logic [CW-1:0]    r_cnt [N_BTN];
  logic [N_BTN-1:0] r_level;
  logic [N_BTN-1:0] r_pending;
  logic [N_BTN-1:0] r_overrun;
  state_t           r_state;
  logic             r_evt_valid;
  logic [ID_W-1:0]  r_evt_id;
  logic [ID_W-1:0]  r_last_grant;

  logic [N_BTN-1:0] w_at_max;
  logic [N_BTN-1:0] w_press;
  logic [N_BTN-1:0] w_clr_mask;
  logic [N_BTN-1:0] w_ovr_set;
  logic             w_found;
  logic [ID_W-1:0]  w_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  // Two-flop synchroniser and per-bit stability filter.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_level <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < N_BTN; i++) begin
        if (r_sync2[i] == r_level[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_level[i] <= ~r_level[i];
          r_cnt[i]   <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // A press is the filter edge on which the level flips from 0 to 1.
  always_comb begin
    w_at_max = '0;
    for (int i = 0; i < N_BTN; i++) begin
      w_at_max[i] = (r_cnt[i] == CNT_MAX);
    end
    w_press = r_sync2 & ~r_level & w_at_max;
  end

  // Round-robin search starting one past the last granted button.
  always_comb begin
    logic [ID_W-1:0] v_idx;
    w_found = 1'b0;
    w_grant = '0;
    v_idx   = '0;
    for (int k = 1; k <= N_BTN; k++) begin
      v_idx = ID_W'((int'(r_last_grant) + k) % N_BTN);
      if (!w_found && r_pending[v_idx]) begin
        w_found = 1'b1;
        w_grant = v_idx;
      end
    end
  end

  always_comb begin
    w_clr_mask = '0;
    if (r_state == S_IDLE && w_found) begin
      w_clr_mask[w_grant] = 1'b1;
    end
  end

  // A press on the bit being granted this cycle just re-arms pending; it is
  // not a lost press.
  assign w_ovr_set = w_press & r_pending & ~w_clr_mask;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_pending <= '0;
      r_overrun <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr_mask) | w_press;
      r_overrun <= (ovr_clr ? '0 : r_overrun) | w_ovr_set;
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state      <= S_IDLE;
      r_evt_valid  <= 1'b0;
      r_evt_id     <= '0;
      r_last_grant <= ID_W'(N_BTN - 1);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_evt_id    <= w_grant;
            r_evt_valid <= 1'b1;
            r_state     <= S_OFFER;
          end
        end
        S_OFFER: begin
          if (evt_ready) begin
            r_evt_valid  <= 1'b0;
            r_last_grant <= r_evt_id;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_evt_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign btn_level = r_level;
  assign evt_valid = r_evt_valid;
  assign evt_id    = r_evt_id;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_btn_event_arbiter.sv
// tb/tb_btn_event_arbiter.sv - directed self-checking bench for btn_event_arbiter
module tb_btn_event_arbiter;

  localparam int N_BTN = 4;
  localparam int SC    = 4;
  localparam int ID_W  = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N_BTN-1:0] btn_raw = '0;
  logic [N_BTN-1:0] btn_level;
  logic             evt_valid;
  logic [ID_W-1:0]  evt_id;
  logic             evt_ready = 1'b1;
  logic [N_BTN-1:0] overrun;
  logic             ovr_clr = 1'b0;

  int checks = 0;
  int errors = 0;
  int n_acc  = 0;
  int cyc    = 0;
  int acc_cyc[$];
  logic [ID_W-1:0] exp_q[$];
  logic [ID_W-1:0] m_exp;

  btn_event_arbiter #(
    .N_BTN(N_BTN),
    .STABLE_CYCLES(SC),
    .ID_W(ID_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .evt_valid(evt_valid),
    .evt_id(evt_id),
    .evt_ready(evt_ready),
    .overrun(overrun),
    .ovr_clr(ovr_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Every accepted event must match the next expected id in the scoreboard.
  always @(negedge clk) begin
    if (evt_valid && evt_ready) begin
      if (exp_q.size() > 0) m_exp = exp_q.pop_front();
      else m_exp = 'x;
      checks++;
      assert (evt_id === m_exp) else begin
        errors++;
        $error("FAIL evt_id: observed=%0d expected=%0d", evt_id, m_exp);
      end
      n_acc++;
      acc_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int k = 0;
    while (!evt_valid && k < budget) begin
      tick();
      k++;
    end
    chk(tag, 32'(evt_valid), 32'd1);
  endtask

  task automatic wait_acc(input string tag, input int target, input int budget);
    int k = 0;
    while (n_acc < target && k < budget) begin
      tick();
      k++;
    end
    chk(tag, 32'(n_acc >= target), 32'd1);
  endtask

  task automatic release_all();
    btn_raw = '0;
    repeat (12) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    int base;

    // Reset state
    repeat (2) tick();
    chk("rst_level", 32'(btn_level), 32'h0);
    chk("rst_valid", 32'(evt_valid), 32'h0);
    chk("rst_id", 32'(evt_id), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    rst_n = 1'b1;
    repeat (4) tick();

    // Clean press of button 1
    base = n_acc;
    btn_raw[1] = 1'b1;
    exp_q.push_back(2'd1);
    repeat (5) tick();
    chk("clean_level_early", 32'(btn_level), 32'h0);
    tick();
    chk("clean_level_rise", 32'(btn_level), 32'h2);
    chk("clean_no_valid_yet", 32'(evt_valid), 32'h0);
    tick();
    chk("clean_valid", 32'(evt_valid), 32'h1);
    chk("clean_id", 32'(evt_id), 32'h1);
    tick();
    chk("clean_valid_one_cycle", 32'(evt_valid), 32'h0);
    release_all();
    chk("release_level", 32'(btn_level), 32'h0);
    chk("release_no_event", 32'(n_acc), 32'(base + 1));

    // Bounce rejection on button 0
    base = n_acc;
    for (int c = 0; c < 20; c++) begin
      btn_raw[0] = ((c / 2) % 2 == 0);
      tick();
      chk("bounce_level", 32'(btn_level[0]), 32'h0);
    end
    btn_raw[0] = 1'b1;
    exp_q.push_back(2'd0);
    wait_acc("bounce_event", base + 1, 30);
    repeat (4) tick();
    chk("bounce_single", 32'(n_acc), 32'(base + 1));
    release_all();

    // Round-robin from reset priority
    do_reset();
    base = n_acc;
    btn_raw = 4'b1101;
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
    wait_acc("rr_three", base + 3, 30);
    if (acc_cyc.size() >= base + 3) begin
      chk("rr_gap1", 32'(acc_cyc[base + 1] - acc_cyc[base]), 32'd2);
      chk("rr_gap2", 32'(acc_cyc[base + 2] - acc_cyc[base + 1]), 32'd2);
    end
    release_all();
    base = n_acc;
    btn_raw = 4'b0101;
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd2);
    wait_acc("rr_wrap", base + 2, 30);
    release_all();

    // Backpressure with a press during the stall
    base = n_acc;
    evt_ready = 1'b0;
    btn_raw[2] = 1'b1;
    exp_q.push_back(2'd2);
    wait_valid("bp_valid_rise", 20);
    btn_raw[1] = 1'b1;
    exp_q.push_back(2'd1);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("bp_valid_hold", 32'(evt_valid), 32'h1);
      chk("bp_id_hold", 32'(evt_id), 32'h2);
    end
    evt_ready = 1'b1;
    wait_acc("bp_events", base + 2, 30);
    release_all();

    // Overrun on button 3
    base = n_acc;
    evt_ready = 1'b0;
    btn_raw[3] = 1'b1;
    exp_q.push_back(2'd3);
    wait_valid("ovr_first_grant", 20);
    btn_raw[3] = 1'b0;
    repeat (8) tick();
    btn_raw[3] = 1'b1;
    exp_q.push_back(2'd3);
    repeat (8) tick();
    chk("ovr_second_pending", 32'(overrun), 32'h0);
    btn_raw[3] = 1'b0;
    repeat (8) tick();
    btn_raw[3] = 1'b1;
    repeat (5) tick();
    chk("ovr_third_early", 32'(overrun), 32'h0);
    tick();
    chk("ovr_third_set", 32'(overrun), 32'h8);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("ovr_clear", 32'(overrun), 32'h0);
    btn_raw[3] = 1'b0;
    repeat (8) tick();
    btn_raw[3] = 1'b1;
    repeat (5) tick();
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("ovr_set_wins", 32'(overrun), 32'h8);
    evt_ready = 1'b1;
    wait_acc("ovr_events", base + 2, 30);
    repeat (4) tick();
    chk("ovr_event_count", 32'(n_acc), 32'(base + 2));
    release_all();

    // Reset in the middle of an offer with another press pending
    base = n_acc;
    evt_ready = 1'b0;
    btn_raw = 4'b0110;
    wait_valid("mid_valid", 20);
    chk("mid_id", 32'(evt_id), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(evt_valid), 32'h0);
    chk("mid_rst_id", 32'(evt_id), 32'h0);
    chk("mid_rst_level", 32'(btn_level), 32'h0);
    chk("mid_rst_overrun", 32'(overrun), 32'h0);
    btn_raw = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    evt_ready = 1'b1;
    repeat (20) tick();
    chk("mid_no_event", 32'(n_acc), 32'(base));
    chk("mid_valid_low", 32'(evt_valid), 32'h0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
